// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: request bundle, lock FSM states, sizes.
// Alignment helper is used only when DMEM_ARB_ALIGN_CHECK_EN is defined.
package dmem_arb_pkg;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
  } dmem_req_t;

  function automatic logic req_bad(
    input dmem_req_t r,
    input int        mem_size
  );
    logic        sz_ok;
    logic        mis;
    logic [64:0] end_a;
    sz_ok = (r.size == SZ_B) || (r.size == SZ_H) ||
            (r.size == SZ_W) || (r.size == SZ_D);
    mis   = |(r.addr & {60'd0, r.size - 4'd1});
    end_a = {1'b0, r.addr} + {61'd0, r.size};
    return !sz_ok || mis || (end_a > 65'(mem_size));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-requester bus into dmem_arbiter.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0]       req_lock;
  logic [1:0][63:0] req_addr;
  logic [1:0][63:0] req_wdata;
  logic [1:0][3:0]  req_size;
  logic [1:0]       rsp_valid;
  logic [63:0]      rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_lock,
    output req_addr, req_wdata, req_size,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_lock,
    input  req_addr, req_wdata, req_size,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way round-robin picker.
// A lock restricts the grant to the lock owner.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  input  arb_state_e i_lock_state,
  input  logic       i_lock_owner,
  output logic [1:0] o_grant,
  output logic       o_any
);

  // Locked owner only; otherwise the port that did not win last
  always_comb begin
    o_grant = 2'b00;
    if (i_lock_state == LOCKED)
      o_grant[i_lock_owner] = i_valid[i_lock_owner];
    else if (&i_valid)
      o_grant[~i_last_grant] = 1'b1;
    else
      o_grant = i_valid;
  end

  assign o_any = |o_grant;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU (port 0) and debug DMA (port 1).
// Optional macro DMEM_ARB_ALIGN_CHECK_EN rejects bad size/align/range.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_arbiter_if.slave io_bus,
  output logic [63:0] o_mem_address,
  output logic        o_mem_write_enable,
  output logic        o_mem_read_enable,
  output logic [63:0] o_mem_write_data,
  output logic [3:0]  o_mem_xfer_size,
  input  logic [63:0] i_mem_read_data
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e      r_state;
  logic            r_owner;
  logic            r_last;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_rsp_valid;
  logic [63:0]     r_rdata;
  logic            r_err;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [3:0]      r_size;

  logic [1:0]      w_pick;
  logic            w_any;
  logic [1:0]      w_grant;
  logic            w_xfer;
  logic            w_win;
  logic            w_bad;
  logic            w_fwd;
  logic [CW-1:0]   w_cnt_nxt;
  dmem_req_t       w_req;

  dmem_rr_pick u_pick (
    .i_valid      (io_bus.req_valid),
    .i_last_grant (r_last),
    .i_lock_state (r_state),
    .i_lock_owner (r_owner),
    .o_grant      (w_pick),
    .o_any        (w_any)
  );

  assign w_grant   = reset ? 2'b00 : w_pick;
  assign w_xfer    = w_any & ~reset;
  assign w_win     = w_grant[1];
  assign w_cnt_nxt = r_cnt + CW'(1);

  // Winner's request fields
  always_comb begin
    w_req.we    = io_bus.req_we[w_win];
    w_req.lock  = io_bus.req_lock[w_win];
    w_req.addr  = io_bus.req_addr[w_win];
    w_req.wdata = io_bus.req_wdata[w_win];
    w_req.size  = io_bus.req_size[w_win];
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign w_bad = req_bad(w_req, MEM_SIZE);
`else
  assign w_bad = 1'b0;
`endif

  assign w_fwd = w_xfer & ~w_bad;

  assign io_bus.req_ready = w_grant;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.rsp_err   = r_err;

  assign o_mem_write_enable = w_fwd & w_req.we;
  assign o_mem_read_enable  = w_fwd & ~w_req.we;
  assign o_mem_address      = w_xfer ? w_req.addr  : r_addr;
  assign o_mem_write_data   = w_xfer ? w_req.wdata : r_wdata;
  assign o_mem_xfer_size    = w_xfer ? w_req.size  : r_size;

  // Response registers, round-robin history and bounded lock FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_rsp_valid <= 2'b00;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
    end else begin
      r_rsp_valid <= w_grant;
      r_err       <= w_xfer & w_bad;
      if (w_xfer) begin
        r_last  <= w_win;
        r_addr  <= w_req.addr;
        r_wdata <= w_req.wdata;
        r_size  <= w_req.size;
        if (!w_req.we && !w_bad)
          r_rdata <= i_mem_read_data;
      end
      unique case (r_state)
        ARB: begin
          if (w_xfer && w_req.lock && (LOCK_MAX > 1)) begin
            r_state <= LOCKED;
            r_owner <= w_win;
            r_cnt   <= CW'(1);
          end
        end
        LOCKED: begin
          if (!io_bus.req_valid[r_owner]) begin
            r_state <= ARB;
          end else if (w_xfer) begin
            if (!w_req.lock || (w_cnt_nxt >= CW'(LOCK_MAX)))
              r_state <= ARB;
            else
              r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory model, shadow reference model,
// directed scenarios followed by randomized traffic.
module tb_dmem_arbiter;

  localparam int MS = 1024;
  localparam int LM = 8;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  logic [63:0] mem_address;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_write_data;
  logic [3:0]  mem_size;
  logic [63:0] mem_read_data;

  dmem_arbiter #(.MEM_SIZE(MS), .LOCK_MAX(LM)) dut (
    .clk                (clk),
    .reset              (reset),
    .io_bus             (bus.slave),
    .o_mem_address      (mem_address),
    .o_mem_write_enable (mem_we),
    .o_mem_read_enable  (mem_re),
    .o_mem_write_data   (mem_write_data),
    .o_mem_xfer_size    (mem_size),
    .i_mem_read_data    (mem_read_data)
  );

  logic [7:0] dev [MS];
  logic [7:0] shd [MS];

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(mem_size))
        mem_read_data[8*i +: 8] =
          dev[(int'(mem_address % 64'(MS)) + i) % MS];
  end

  always @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 8; i++)
        if (i < int'(mem_size))
          dev[(int'(mem_address % 64'(MS)) + i) % MS] <=
            mem_write_data[8*i +: 8];

  int checks = 0;
  int errors = 0;

  int          m_owner = -1;
  int          m_streak = 0;
  int          m_prefer = 0;
  logic [1:0]  e_rv;
  logic [63:0] e_rd;
  logic        e_err;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit bad_req(input logic [63:0] a,
                                 input logic [3:0] s);
    bit b;
    b = 1'b0;
    if (!(s == 1 || s == 2 || s == 4 || s == 8)) b = 1'b1;
    else if (a % 64'(s) != 0) b = 1'b1;
    else if (({1'b0, a} + 65'(s)) > 65'(MS)) b = 1'b1;
    return CHK_EN && b;
  endfunction

  task automatic set_req(input int p, input bit v, input bit we,
                         input bit lk, input logic [63:0] a,
                         input logic [63:0] d, input logic [3:0] s);
    bus.req_valid[p] = v;
    bus.req_we[p]    = we;
    bus.req_lock[p]  = lk;
    bus.req_addr[p]  = a;
    bus.req_wdata[p] = d;
    bus.req_size[p]  = s;
  endtask

  task automatic idle();
    set_req(0, 0, 0, 0, 0, 0, 1);
    set_req(1, 0, 0, 0, 0, 0, 1);
  endtask

  // One clock: predict grant and response, check pins and response.
  task automatic cycle(output int w);
    logic [1:0]  v;
    logic [1:0]  exp_ready;
    logic [63:0] a;
    logic [3:0]  s;
    bit          bad;
    bit          we;
    @(negedge clk);
    v = bus.req_valid;
    w = -1;
    if (!reset) begin
      if (m_owner >= 0) begin
        if (v[m_owner]) w = m_owner;
      end else if (v == 2'b11) w = m_prefer;
      else if (v[0]) w = 0;
      else if (v[1]) w = 1;
    end
    exp_ready = (w < 0) ? 2'b00 : 2'(1 << w);
    chk("ready", bus.req_ready, exp_ready);
    if (w >= 0) begin
      a   = bus.req_addr[w];
      s   = bus.req_size[w];
      we  = bus.req_we[w];
      bad = bad_req(a, s);
      chk("wen", mem_we, !bad && we);
      chk("ren", mem_re, !bad && !we);
      chk("addr", mem_address, a);
      chk("size", mem_size, s);
      chk("wdata", mem_write_data, bus.req_wdata[w]);
      e_rv  = exp_ready;
      e_err = bad;
      if (!bad) begin
        if (we) begin
          for (int i = 0; i < int'(s) && i < 8; i++)
            shd[(int'(a % 64'(MS)) + i) % MS] = bus.req_wdata[w][8*i +: 8];
        end else begin
          e_rd = '0;
          for (int i = 0; i < int'(s) && i < 8; i++)
            e_rd[8*i +: 8] = shd[(int'(a % 64'(MS)) + i) % MS];
        end
      end
    end else begin
      chk("wen_idle", mem_we, 1'b0);
      chk("ren_idle", mem_re, 1'b0);
      e_rv  = 2'b00;
      e_err = 1'b0;
    end
    if (reset) begin
      m_owner  = -1;
      m_prefer = 0;
      e_rd     = '0;
    end else if (m_owner >= 0 && !v[m_owner]) begin
      m_owner = -1;
    end else if (w >= 0) begin
      m_prefer = 1 - w;
      if (m_owner < 0) begin
        if (bus.req_lock[w]) begin
          m_streak = 1;
          if (LM > 1) m_owner = w;
        end
      end else begin
        m_streak++;
        if (!bus.req_lock[w] || m_streak >= LM) m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("rsp_rdata", bus.rsp_rdata, e_rd);
    chk("rsp_err", bus.rsp_err, e_err);
  endtask

  logic [1:0]  pat [11];
  logic [3:0]  sz_tab [4];
  logic [63:0] ra;
  logic [3:0]  rs;
  int          w;

  initial begin
    sz_tab[0] = 4'd1; sz_tab[1] = 4'd2;
    sz_tab[2] = 4'd4; sz_tab[3] = 4'd8;
    for (int i = 0; i < MS; i++) shd[i] = 8'hxx;
    e_rv = 0; e_rd = 0; e_err = 0;
    reset = 1'b1;
    idle();
    cycle(w);
    cycle(w);
    chk("rst_rdata", bus.rsp_rdata, 64'd0);
    reset = 1'b0;

    // write then read back on port 0
    set_req(0, 1, 1, 0, 64'h10, 64'h1122334455667788, 4'd8);
    cycle(w);
    set_req(0, 1, 0, 0, 64'h10, 64'h0, 4'd8);
    cycle(w);
    chk("t1_rv", bus.rsp_valid, 2'b01);
    chk("t1_rdata", bus.rsp_rdata, 64'h1122334455667788);
    idle();
    cycle(w);

    // alternating grants after reset
    reset = 1'b1;
    cycle(w);
    reset = 1'b0;
    set_req(0, 1, 0, 0, 64'h10, 0, 4'd8);
    set_req(1, 1, 0, 0, 64'h10, 0, 4'd4);
    for (int i = 0; i < 4; i++) begin
      cycle(w);
      chk("t2_alt", bus.rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle();
    cycle(w);

    // bounded lock on port 1
    reset = 1'b1;
    cycle(w);
    reset = 1'b0;
    pat[0] = 2'b01;
    for (int i = 1; i <= 8; i++) pat[i] = 2'b10;
    pat[9] = 2'b01;
    pat[10] = 2'b10;
    set_req(0, 1, 0, 0, 64'h18, 0, 4'd8);
    set_req(1, 1, 0, 1, 64'h10, 0, 4'd8);
    for (int i = 0; i < 11; i++) begin
      cycle(w);
      chk("t3_lock", bus.rsp_valid, pat[i]);
    end
    idle();
    cycle(w);

    // misaligned halfword write
    set_req(0, 1, 1, 0, 64'h21, 64'hBEEF, 4'd2);
    cycle(w);
    if (CHK_EN) chk("t4_err", bus.rsp_err, 1'b1);
    chk("t4_mem", {56'd0, dev[33]}, {56'd0, shd[33]});
    idle();
    cycle(w);

    // write presented during reset
    reset = 1'b1;
    set_req(0, 1, 1, 0, 64'h40, 64'hA5A5, 4'd2);
    cycle(w);
    chk("t5_rv", bus.rsp_valid, 2'b00);
    chk("t5_mem", {56'd0, dev[64]}, {56'd0, 8'hxx});
    reset = 1'b0;
    idle();
    cycle(w);

    // upper boundary on port 1
    set_req(1, 1, 0, 0, 64'h3FF, 0, 4'd1);
    cycle(w);
    chk("t6_err_b", bus.rsp_err, 1'b0);
    set_req(1, 1, 0, 0, 64'h3F8, 0, 4'd8);
    cycle(w);
    chk("t6_err_d", bus.rsp_err, 1'b0);
    set_req(1, 1, 0, 0, 64'h400, 0, 4'd8);
    cycle(w);
    chk("t6_err_oob", bus.rsp_err, CHK_EN);
    idle();
    cycle(w);

    // randomized traffic
    w = -1;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(63) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!(bus.req_valid[p] && w != p)) begin
          rs = sz_tab[$urandom_range(3)];
          ra = 64'($urandom_range(MS / int'(rs) - 1)) * 64'(rs);
          if (CHK_EN && $urandom_range(7) == 0) begin
            rs = 4'($urandom_range(15));
            ra = 64'($urandom_range(MS + 15));
          end
          set_req(p, $urandom_range(3) != 0, $urandom_range(1) == 1,
                  $urandom_range(2) == 0, ra,
                  {$urandom, $urandom}, rs);
        end
      end
      cycle(w);
    end
    reset = 1'b0;
    idle();
    cycle(w);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-ported byte-addressed data memory between two requesters: port 0 is the CPU MEM stage and port 1 is the debug/loader DMA. The block grants at most one access per cycle using round-robin with an optional bounded lock. It drives the memory's address, enable, data and size pins, and returns registered read data / error to the granted requester one cycle later.

Parameters:
MEM_SIZE, 1024, memory bytes; power of two, >8; used for the bounds check
LOCK_MAX, 8, maximum consecutive locked grants to one port before forced release (>=1)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
req_valid  in  2  per-port request valid
req_ready  out  2  per-port accept; a transfer occurs when valid&ready
req_we  in  2  per-port 1=write, 0=read
req_lock  in  2  per-port request to keep grant after this access
req_addr  in  2x64  per-port byte address
req_wdata  in  2x64  per-port write data, little-endian
req_size  in  2x4  per-port transfer size: 1, 2, 4 or 8
rsp_valid  out  2  per-port response strobe, one cycle
rsp_rdata  out  64  read data for the port flagged by rsp_valid
rsp_err  out  1  access rejected (alignment feature only)
mem_address  out  64  to memory address
mem_write_enable  out  1  to memory write enable
mem_read_enable  out  1  to memory read enable
mem_write_data  out  64  to memory write data
mem_xfer_size  out  4  to memory transfer size
mem_read_data  in  64  combinational read data from memory

Behaviour:
- Reset (sync): state=ARB, last_grant=1 (port 0 wins the first tie), lock_cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. While reset is high: req_ready=0, mem_write_enable=0, mem_read_enable=0.
- Grant is combinational in cycle T.
  - State ARB, one valid port: that port wins.
  - State ARB, both ports valid: the port != last_grant wins.
  - State LOCKED(p): only port p can win; the other port's ready=0.
- Winner w: req_ready[w]=1, all other ready bits 0. Memory pins driven from w's request.
  - mem_write_enable=req_we[w]; mem_read_enable=~req_we[w].
  - No winner: both enables 0, address/data/size hold their last driven values (no X).
- Posedge ending T, on a transfer:
  - last_grant<=w.
  - rsp_valid[w]<=1 in T+1 only; rsp_rdata<=mem_read_data for reads, unchanged for writes.
  - The write commits in memory at the same edge.
  - Read latency 1; write-response latency 1; throughput 1 access/cycle.
- Lock FSM, states ARB and LOCKED(p):
  - ARB -> LOCKED(w) on a transfer with req_lock[w]=1; lock_cnt<=1.
  - LOCKED(p), transfer with req_lock[p]=1 and lock_cnt<LOCK_MAX: stay; lock_cnt++.
  - LOCKED(p), transfer with lock_cnt==LOCK_MAX: -> ARB and force last_grant=p, so the other port wins the next tie.
  - LOCKED(p), transfer with req_lock[p]=0: -> ARB.
  - LOCKED(p), req_valid[p]=0 for a cycle: -> ARB immediately; no idle lock holding.
- Requester rule: while valid and not ready, the request fields are held stable. The arbiter does not check this.
- Reset mid-access: the access in the reset cycle is not granted and not written; any pending rsp_valid is cleared.

Optional Feature:
DMEM_ARB_ALIGN_CHECK_EN
- Defined: before granting, the arbiter checks the winner's request.
  - Reject if size is not in {1,2,4,8}, or addr & (size-1) != 0, or addr+size > MEM_SIZE.
  - A rejected request still gets ready=1 and consumes the grant, but both memory enables stay 0.
  - Next cycle: rsp_valid[w]=1, rsp_err=1, rsp_rdata unchanged.
- Undefined: no check; every granted request is forwarded; rsp_err is tied 0.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef struct dmem_req_t {we, lock, addr[63:0], wdata[63:0], size[3:0]};
  - enum arb_state_e {ARB, LOCKED};
  - size constants SZ_B=1, SZ_H=2, SZ_W=4, SZ_D=8.
- One sub-module, dmem_rr_pick: combinational 2-way round-robin picker.
  - Inputs: valid[1:0], last_grant, lock_state, lock_owner.
  - Outputs: grant one-hot, any.
- The FSM and registers stay in dmem_arbiter.

Test Plan:
- Port 0 writes 0x1122334455667788 size 8 at addr 0x10, then reads size 8 at 0x10 -> rsp_valid[0] one cycle later, rsp_rdata=0x1122334455667788.
- Both ports valid with reads for 4 cycles after reset -> grants 0,1,0,1; each rsp_valid one cycle after its grant.
- Port 1 holds req_lock=1 with continuous reads while port 0 also requests, LOCK_MAX=8 -> port 1 granted 8 consecutive cycles, then port 0 granted, then port 1.
- Port 0 writes size 2 at addr 0x21 with DMEM_ARB_ALIGN_CHECK_EN defined -> mem_write_enable stays 0, next cycle rsp_err=1, memory contents unchanged.
- Port 0 write grant in the same cycle reset=1 -> req_ready=0, mem_write_enable=0, rsp_valid=0 next cycle, location still X.
- Port 1 reads size 1 at addr 0x3FF, then size 8 at 0x3F8 -> both accepted and no error; size 8 at 0x400 -> rsp_err=1 with the check enabled.
